// File: rtl/cnn_pkg.sv
// Shared sizes, FSM state encoding and beat index type for the conv output stage.
package cnn_pkg;

  localparam int N_CH      = 8;
  localparam int CONV_X    = 24;
  localparam int CONV_Y    = 24;
  localparam int CONV_SIZE = 69;
  localparam int OUT_W     = 32;

  localparam int CH_W  = 3;
  localparam int ROW_W = 5;
  localparam int COL_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    STREAM,
    FINISH
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0]  chan;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } idx_t;

endpackage

// File: rtl/conv_sat_relu.sv
// Combinational saturator from a wide conv result to a narrow signed output word.
// Define CONV_STREAM_RELU_EN to force negative saturated values to zero.
module conv_sat_relu
  import cnn_pkg::*;
(
  input  logic signed [CONV_SIZE-1:0] din,
  output logic signed [OUT_W-1:0]     dout
);

  logic signed [OUT_W-1:0] sat;
  logic [CONV_SIZE-OUT_W:0] top_bits;

  assign top_bits = din[CONV_SIZE-1:OUT_W-1];

  // The value fits when every bit above the output sign bit copies it.
  always_comb begin
    sat = din[OUT_W-1:0];
    if (!(&top_bits) && (|top_bits)) begin
      if (din[CONV_SIZE-1]) sat = {1'b1, {(OUT_W-1){1'b0}}};
      else                  sat = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

`ifdef CONV_STREAM_RELU_EN
  assign dout = sat[OUT_W-1] ? '0 : sat;
`else
  assign dout = sat;
`endif

endmodule

// File: rtl/conv_result_streamer.sv
// Runs one conv layer pass on start, then streams all result maps as saturated beats.
// Define CONV_STREAM_RELU_EN to clamp negative output words to zero.
module conv_result_streamer
  import cnn_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        conv_enable,
  input  logic                        conv_done,
  input  logic signed [CONV_SIZE-1:0] conv_result [N_CH][CONV_X][CONV_Y],
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [OUT_W-1:0]     m_data,
  output logic [CH_W-1:0]             m_chan,
  output logic [ROW_W-1:0]            m_row,
  output logic [COL_W-1:0]            m_col,
  output logic                        m_last,
  output logic                        m_frame_last,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err
);

  state_t                      state;
  idx_t                        cur;
  idx_t                        nxt;
  idx_t                        sel;
  logic signed [CONV_SIZE-1:0] elem;
  logic signed [OUT_W-1:0]     sat_data;
  logic                        sel_last;
  logic                        sel_frame_last;

  assign cur  = {m_chan, m_row, m_col};
  assign busy = (state != IDLE);

  // Column runs fastest, then row, then channel.
  always_comb begin
    nxt = cur;
    if (cur.col == COL_W'(CONV_Y - 1)) begin
      nxt.col = '0;
      if (cur.row == ROW_W'(CONV_X - 1)) begin
        nxt.row  = '0;
        nxt.chan = cur.chan + CH_W'(1);
      end else begin
        nxt.row = cur.row + ROW_W'(1);
      end
    end else begin
      nxt.col = cur.col + COL_W'(1);
    end
  end

  // Outside STREAM the only beat ever loaded is the first one.
  assign sel            = (state == STREAM) ? nxt : '0;
  assign elem           = conv_result[sel.chan][sel.row][sel.col];
  assign sel_last       = (sel.row == ROW_W'(CONV_X - 1)) && (sel.col == COL_W'(CONV_Y - 1));
  assign sel_frame_last = sel_last && (sel.chan == CH_W'(N_CH - 1));

  conv_sat_relu u_sat (
    .din  (elem),
    .dout (sat_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      conv_enable  <= 1'b0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_chan       <= '0;
      m_row        <= '0;
      m_col        <= '0;
      m_last       <= 1'b0;
      m_frame_last <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            conv_enable <= 1'b1;
            err         <= 1'b0;
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (conv_done) begin
            m_valid                 <= 1'b1;
            m_data                  <= sat_data;
            {m_chan, m_row, m_col}  <= sel;
            m_last                  <= sel_last;
            m_frame_last            <= sel_frame_last;
            state                   <= STREAM;
          end
        end
        STREAM: begin
          // Losing conv_done mid-stream means the results are no longer trustworthy.
          if (!conv_done) begin
            err                    <= 1'b1;
            m_valid                <= 1'b0;
            conv_enable            <= 1'b0;
            m_data                 <= '0;
            {m_chan, m_row, m_col} <= '0;
            m_last                 <= 1'b0;
            m_frame_last           <= 1'b0;
            state                  <= IDLE;
          end else if (m_valid && m_ready) begin
            if (m_frame_last) begin
              m_valid                <= 1'b0;
              conv_enable            <= 1'b0;
              m_data                 <= '0;
              {m_chan, m_row, m_col} <= '0;
              m_last                 <= 1'b0;
              m_frame_last           <= 1'b0;
              frame_done             <= 1'b1;
              state                  <= FINISH;
            end else begin
              m_data                 <= sat_data;
              {m_chan, m_row, m_col} <= sel;
              m_last                 <= sel_last;
              m_frame_last           <= sel_frame_last;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
